// File: rtl/maccum_pkg.sv
// maccum_pkg: FSM encodings, beat/width helpers and the accumulator-to-output conversion.
// Conversion saturates when MACCUM_SAT_EN is defined, otherwise wraps.
`default_nettype none

package maccum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  function automatic int nb(input int np, input int nl);
    return (np + nl - 1) / nl;
  endfunction

  function automatic int wa_width(input int np, input int wf);
    return 2 * wf + $clog2(np + 1);
  endfunction

  // Input is the accumulator already sign-extended to 64 bits; caller keeps the low wo bits.
  function automatic logic signed [63:0] acc_convert(input logic signed [63:0] a,
                                                     input int wa, input int wo);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] r;
    hi = (64'sd1 <<< (wo - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    r  = a;
    if (wo < wa) begin
`ifdef MACCUM_SAT_EN
      if (a > hi) r = hi;
      else if (a < lo) r = lo;
`else
      r = a;
`endif
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/maccum_if.sv
// maccum_if: operand inputs (weight/bias, state) and the forked result output of maccum_folded.
`default_nettype none

interface maccum_if #(
  parameter int NP = 3,
  parameter int NC = 2,
  parameter int WF = 8,
  parameter int NO = 2,
  parameter int WO = 2 * WF + $clog2(NP + 1)
);
  logic                       wb_valid;
  logic                       wb_ready;
  logic [NP*NC*WF+NC*WF-1:0]  wb_data;
  logic                       st_valid;
  logic                       st_ready;
  logic [NP*WF-1:0]           st_data;
  logic [NO-1:0]              acc_valid;
  logic [NO-1:0]              acc_ready;
  logic [NC*WO-1:0]           acc_data;

  modport master (
    output wb_valid, wb_data, st_valid, st_data, acc_ready,
    input  wb_ready, st_ready, acc_valid, acc_data
  );

  modport slave (
    input  wb_valid, wb_data, st_valid, st_data, acc_ready,
    output wb_ready, st_ready, acc_valid, acc_data
  );
endinterface

`default_nettype wire

// File: rtl/mac_lane.sv
// mac_lane: NL signed WF x WF products summed into a WA-bit result for one child, one beat.
`default_nettype none

module mac_lane #(
  parameter int NL = 1,
  parameter int WF = 8,
  parameter int WA = 18
) (
  input  wire logic [NL*WF-1:0]    w,
  input  wire logic [NL*WF-1:0]    s,
  output logic signed [WA-1:0]     sum
);
  logic signed [2*WF-1:0] prod [NL];

  always_comb begin
    sum = '0;
    for (int l = 0; l < NL; l++) begin
      prod[l] = $signed(w[l*WF +: WF]) * $signed(s[l*WF +: WF]);
      sum     = sum + {{(WA-2*WF){prod[l][2*WF-1]}}, prod[l]};
    end
  end
endmodule

`default_nettype wire

// File: rtl/maccum_folded.sv
// maccum_folded: folded signed MAC y[c] = b[c] + sum_p w[p][c]*s[p] over NB beats with an NO-way output fork.
// Optional MACCUM_SAT_EN selects saturating (instead of wrapping) narrowing of the result.
`default_nettype none

module maccum_folded
  import maccum_pkg::*;
#(
  parameter int    NP    = 3,
  parameter int    NC    = 2,
  parameter int    WF    = 8,
  parameter int    NL    = 1,
  parameter int    NO    = 2,
  parameter int    WO    = 2 * WF + $clog2(NP + 1),
  parameter string BURST = "yes"
) (
  input wire logic clk,
  input wire logic rst,
  maccum_if.slave  bus
);
  localparam int WA       = wa_width(NP, WF);
  localparam int NB       = nb(NP, NL);
  localparam int KW       = (NB > 1) ? $clog2(NB) : 1;
  localparam int WBW      = NP * NC * WF + NC * WF;
  localparam bit BURST_EN = (BURST == "yes");

  state_t                state, state_next;
  logic [WBW-1:0]        wb_hold;
  logic [NP*WF-1:0]      st_hold;
  logic                  have_wb, have_st;
  logic [KW-1:0]         beat;
  logic signed [WA-1:0]  acc      [NC];
  logic signed [WA-1:0]  lane_sum [NC];
  logic signed [WA-1:0]  acc_sum  [NC];
  logic signed [WA-1:0]  bias_ext [NC];
  logic [NL*WF-1:0]      lane_w   [NC];
  logic [NL*WF-1:0]      lane_s;
  logic [NO-1:0]         out_valid;
  logic [NC*WO-1:0]      out_data, out_next;
  logic                  in_open, wb_fire, st_fire, start, last_beat;
  logic                  load_out, clear_have;
  logic [NC*WF-1:0]      bias_src;

  // Without burst, operands are only taken once the previous result has fully drained.
  assign in_open      = BURST_EN ? 1'b1 : (state == ST_IDLE && out_valid == '0);
  assign bus.wb_ready = !have_wb && !rst && in_open;
  assign bus.st_ready = !have_st && !rst && in_open;
  assign wb_fire      = bus.wb_valid && bus.wb_ready;
  assign st_fire      = bus.st_valid && bus.st_ready;
  assign start        = (have_wb || wb_fire) && (have_st || st_fire);
  assign last_beat    = (beat == KW'(NB - 1));
  assign bias_src     = wb_fire ? bus.wb_data[NC*WF-1:0] : wb_hold[NC*WF-1:0];
  assign bus.acc_valid = out_valid;
  assign bus.acc_data  = out_data;

  always_comb begin
    int p;
    lane_s = '0;
    for (int c = 0; c < NC; c++) lane_w[c] = '0;
    for (int l = 0; l < NL; l++) begin
      p = int'(beat) * NL + l;
      if (p < NP) begin
        lane_s[l*WF +: WF] = st_hold[p*WF +: WF];
        for (int c = 0; c < NC; c++)
          lane_w[c][l*WF +: WF] = wb_hold[(p*NC+c)*WF + NC*WF +: WF];
      end
    end
  end

  generate
    for (genvar c = 0; c < NC; c++) begin : g_child
      mac_lane #(.NL(NL), .WF(WF), .WA(WA)) u_lane (
        .w   (lane_w[c]),
        .s   (lane_s),
        .sum (lane_sum[c])
      );
      assign acc_sum[c]  = acc[c] + lane_sum[c];
      assign bias_ext[c] = {{(WA-WF){bias_src[c*WF+WF-1]}}, bias_src[c*WF +: WF]};
    end
  endgenerate

  // From ACC the result is the just-summed value; from HOLD it already sits in acc.
  always_comb begin
    logic signed [63:0] ext;
    logic signed [63:0] conv;
    out_next = '0;
    for (int c = 0; c < NC; c++) begin
      if (state == ST_ACC) ext = {{(64-WA){acc_sum[c][WA-1]}}, acc_sum[c]};
      else                 ext = {{(64-WA){acc[c][WA-1]}}, acc[c]};
      conv = acc_convert(ext, WA, WO);
      out_next[c*WO +: WO] = conv[WO-1:0];
    end
  end

  always_comb begin
    state_next = state;
    load_out   = 1'b0;
    clear_have = 1'b0;
    case (state)
      ST_IDLE: if (start) state_next = ST_ACC;
      ST_ACC: begin
        if (last_beat) begin
          clear_have = 1'b1;
          if (out_valid == '0) begin
            load_out   = 1'b1;
            state_next = ST_IDLE;
          end else begin
            state_next = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (out_valid == '0) begin
          load_out   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      wb_hold   <= '0;
      st_hold   <= '0;
      have_wb   <= 1'b0;
      have_st   <= 1'b0;
      beat      <= '0;
      out_valid <= '0;
      out_data  <= '0;
      for (int c = 0; c < NC; c++) acc[c] <= '0;
    end else begin
      state <= state_next;
      if (wb_fire) begin
        wb_hold <= bus.wb_data;
        have_wb <= 1'b1;
      end
      if (st_fire) begin
        st_hold <= bus.st_data;
        have_st <= 1'b1;
      end
      if (clear_have) begin
        have_wb <= 1'b0;
        have_st <= 1'b0;
      end
      if (state == ST_IDLE && start) begin
        for (int c = 0; c < NC; c++) acc[c] <= bias_ext[c];
        beat <= '0;
      end else if (state == ST_ACC) begin
        for (int c = 0; c < NC; c++) acc[c] <= acc_sum[c];
        beat <= beat + 1'b1;
      end
      for (int i = 0; i < NO; i++)
        if (out_valid[i] && bus.acc_ready[i]) out_valid[i] <= 1'b0;
      if (load_out) begin
        out_valid <= '1;
        out_data  <= out_next;
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_maccum_folded.sv
// tb_maccum_folded: directed vectors for maccum_folded across NL=1, NL=3, WO=8 and BURST="no" builds.
`default_nettype none

module tb_maccum_folded;
  import maccum_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  maccum_if #(.NP(3), .NC(2), .WF(8), .NO(2))          bus  ();
  maccum_if #(.NP(3), .NC(2), .WF(8), .NO(2))          bus3 ();
  maccum_if #(.NP(3), .NC(2), .WF(8), .NO(2), .WO(8))  bus8 ();
  maccum_if #(.NP(3), .NC(2), .WF(8), .NO(2))          busn ();

  maccum_folded #(.NP(3), .NC(2), .WF(8), .NL(1), .NO(2)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  maccum_folded #(.NP(3), .NC(2), .WF(8), .NL(3), .NO(2)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3));
  maccum_folded #(.NP(3), .NC(2), .WF(8), .NL(1), .NO(2), .WO(8)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8));
  maccum_folded #(.NP(3), .NC(2), .WF(8), .NL(1), .NO(2), .BURST("no")) dutn (
    .clk(clk), .rst(rst), .bus(busn));

  typedef struct {
    logic [63:0] wb;
    logic [23:0] st;
    int          y0;
    int          y1;
  } vec_t;

  function automatic logic [63:0] pk(input int w00, input int w01, input int w10,
                                     input int w11, input int w20, input int w21,
                                     input int b0, input int b1);
    return {8'(w21), 8'(w20), 8'(w11), 8'(w10), 8'(w01), 8'(w00), 8'(b1), 8'(b0)};
  endfunction

  function automatic logic [23:0] pks(input int s0, input int s1, input int s2);
    return {8'(s2), 8'(s1), 8'(s0)};
  endfunction

  function automatic int gy(input logic [35:0] d, input int c);
    logic signed [17:0] t;
    t = d[c*18 +: 18];
    return int'(t);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic send_main(input logic [63:0] wb, input logic [23:0] st);
    @(negedge clk);
    bus.wb_valid = 1'b1; bus.wb_data = wb;
    bus.st_valid = 1'b1; bus.st_data = st;
    @(posedge clk); #1;
    bus.wb_valid = 1'b0; bus.st_valid = 1'b0;
  endtask

  // Cycles until acc_valid equals want, or -1 if it never does within the bound.
  task automatic wait_valid(input logic [1:0] want, output int cyc);
    cyc = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (bus.acc_valid == want) begin
        cyc = n;
        break;
      end
    end
  endtask

  vec_t vecs [6];
  int   cyc;
  int   sum_v;

  initial begin
    vecs[0] = '{pk(1, 1, 1, 1, 1, 1, 10, 20), pks(1, 2, 3), 16, 26};
    vecs[1] = '{pk(2, -1, 2, -1, 2, -1, -7, 5), pks(-1, -1, -1), -13, 8};
    vecs[2] = '{pk(1, -2, 3, 4, -5, 6, -100, 50), pks(7, -8, 9), -162, 58};
    vecs[3] = '{pk(-128, -128, -128, -128, -128, -128, 127, 127), pks(-128, -128, -128), 49279, 49279};
    vecs[4] = '{pk(-128, -128, -128, -128, -128, -128, -128, -128), pks(127, 127, 127), -48896, -48896};
    vecs[5] = '{pk(0, 0, 0, 0, 0, 0, -1, 1), pks(5, 6, 7), -1, 1};

    bus.wb_valid = 0;  bus.st_valid = 0;  bus.wb_data = '0;  bus.st_data = '0;  bus.acc_ready = 2'b11;
    bus3.wb_valid = 0; bus3.st_valid = 0; bus3.wb_data = '0; bus3.st_data = '0; bus3.acc_ready = 2'b11;
    bus8.wb_valid = 0; bus8.st_valid = 0; bus8.wb_data = '0; bus8.st_data = '0; bus8.acc_ready = 2'b11;
    busn.wb_valid = 0; busn.st_valid = 0; busn.wb_data = '0; busn.st_data = '0; busn.acc_ready = 2'b00;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(bus.acc_valid), 0);
    chk("rst_data", int'(bus.acc_data != '0), 0);
    chk("rst_wb_ready", int'(bus.wb_ready), 0);
    chk("rst_st_ready", int'(bus.st_ready), 0);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("idle_wb_ready", int'(bus.wb_ready), 1);

    // Table: both operands in the same cycle, fixed latency of NB=3.
    for (int i = 0; i < 6; i++) begin
      send_main(vecs[i].wb, vecs[i].st);
      wait_valid(2'b11, cyc);
      chk($sformatf("vec%0d_latency", i), cyc, 3);
      chk($sformatf("vec%0d_y0", i), gy(bus.acc_data, 0), vecs[i].y0);
      chk($sformatf("vec%0d_y1", i), gy(bus.acc_data, 1), vecs[i].y1);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_drained", i), int'(bus.acc_valid), 0);
    end

    // State arrives 4 cycles ahead of weights.
    @(negedge clk);
    bus.st_valid = 1'b1; bus.st_data = vecs[0].st;
    @(posedge clk); #1;
    bus.st_valid = 1'b0;
    sum_v = 0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      chk("skew_st_ready_low", int'(bus.st_ready), 0);
      sum_v += int'(bus.acc_valid);
    end
    chk("skew_no_early_valid", sum_v, 0);
    @(negedge clk);
    bus.wb_valid = 1'b1; bus.wb_data = vecs[0].wb;
    @(posedge clk); #1;
    bus.wb_valid = 1'b0;
    wait_valid(2'b11, cyc);
    chk("skew_latency", cyc, 3);
    chk("skew_y0", gy(bus.acc_data, 0), 16);
    chk("skew_y1", gy(bus.acc_data, 1), 26);
    @(posedge clk); #1;
    chk("skew_st_ready_back", int'(bus.st_ready), 1);

    // Fork: port 0 drains at once, port 1 stalls while a second burst is computed.
    bus.acc_ready = 2'b01;
    send_main(vecs[0].wb, vecs[0].st);
    wait_valid(2'b11, cyc);
    chk("fork_latency", cyc, 3);
    @(posedge clk); #1;
    chk("fork_valid_10", int'(bus.acc_valid), 2);
    chk("fork_burst_wb_ready", int'(bus.wb_ready), 1);
    send_main(vecs[2].wb, vecs[2].st);
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      chk("fork_hold_valid", int'(bus.acc_valid), 2);
      chk("fork_hold_y0", gy(bus.acc_data, 0), 16);
      chk("fork_hold_y1", gy(bus.acc_data, 1), 26);
    end
    @(negedge clk) bus.acc_ready = 2'b11;
    @(posedge clk); #1;
    chk("fork_released", int'(bus.acc_valid), 0);
    wait_valid(2'b11, cyc);
    chk("fork2_seen", int'(cyc > 0), 1);
    chk("fork2_y0", gy(bus.acc_data, 0), -162);
    chk("fork2_y1", gy(bus.acc_data, 1), 58);
    @(posedge clk); #1;

    // Reset during ACC beat 1 drops the computation.
    send_main(vecs[2].wb, vecs[2].st);
    @(posedge clk); #1;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valid", int'(bus.acc_valid), 0);
    chk("midrst_wb_ready", int'(bus.wb_ready), 0);
    chk("midrst_st_ready", int'(bus.st_ready), 0);
    @(negedge clk) rst = 1'b0;
    sum_v = 0;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      sum_v += int'(bus.acc_valid);
    end
    chk("midrst_result_dropped", sum_v, 0);
    send_main(vecs[0].wb, vecs[0].st);
    wait_valid(2'b11, cyc);
    chk("midrst_fresh_latency", cyc, 3);
    chk("midrst_fresh_y0", gy(bus.acc_data, 0), 16);
    chk("midrst_fresh_y1", gy(bus.acc_data, 1), 26);

    // NL=3: single beat.
    @(negedge clk);
    bus3.wb_valid = 1'b1; bus3.wb_data = vecs[1].wb;
    bus3.st_valid = 1'b1; bus3.st_data = vecs[1].st;
    @(posedge clk); #1;
    bus3.wb_valid = 1'b0; bus3.st_valid = 1'b0;
    cyc = -1;
    for (int n = 1; n <= 10; n++) begin
      if (bus3.acc_valid == 2'b11) begin cyc = n - 1; break; end
      @(posedge clk); #1;
    end
    chk("nl3_latency", cyc, 1);
    chk("nl3_y0", gy(bus3.acc_data, 0), -13);
    chk("nl3_y1", gy(bus3.acc_data, 1), 8);

    // WO=8 narrowing of 48387.
    @(negedge clk);
    bus8.wb_valid = 1'b1; bus8.wb_data = pk(127, 127, 127, 127, 127, 127, 0, 0);
    bus8.st_valid = 1'b1; bus8.st_data = pks(127, 127, 127);
    @(posedge clk); #1;
    bus8.wb_valid = 1'b0; bus8.st_valid = 1'b0;
    cyc = -1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (bus8.acc_valid == 2'b11) begin cyc = n; break; end
    end
    chk("wo8_latency", cyc, 3);
`ifdef MACCUM_SAT_EN
    chk("wo8_y0", int'($signed(bus8.acc_data[7:0])), 127);
    chk("wo8_y1", int'($signed(bus8.acc_data[15:8])), 127);
`else
    chk("wo8_y0", int'(bus8.acc_data[7:0]), 3);
    chk("wo8_y1", int'(bus8.acc_data[15:8]), 3);
`endif

    // BURST="no": inputs blocked until the result is fully drained.
    @(negedge clk);
    busn.wb_valid = 1'b1; busn.wb_data = vecs[0].wb;
    busn.st_valid = 1'b1; busn.st_data = vecs[0].st;
    @(posedge clk); #1;
    busn.wb_valid = 1'b0; busn.st_valid = 1'b0;
    cyc = -1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (busn.acc_valid == 2'b11) begin cyc = n; break; end
    end
    chk("noburst_latency", cyc, 3);
    chk("noburst_y0", gy(busn.acc_data, 0), 16);
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      chk("noburst_wb_ready_low", int'(busn.wb_ready), 0);
      chk("noburst_st_ready_low", int'(busn.st_ready), 0);
    end
    @(negedge clk) busn.acc_ready = 2'b11;
    @(posedge clk); #1;
    chk("noburst_drained", int'(busn.acc_valid), 0);
    chk("noburst_wb_ready_back", int'(busn.wb_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
